// File: rtl/pcie_mrd_tag_sched.sv
// pcie_mrd_tag_sched: round-robin scheduler for upstream MRd requests.
// Each accepted grant holds one PCIe tag and a DW reservation of completion
// credit. Both are returned when the RX checker reports the tag's final completion.
// Optional statistics outputs are enabled by defining PCIE_MRD_SCHED_STATS_EN.
module pcie_mrd_tag_sched #(
   parameter int NUM_REQ        = 4,
   parameter int TAG_WIDTH      = 8,
   parameter int NUM_TAGS       = 64,
   parameter int LEN_WIDTH      = 10,
   parameter int CPL_CREDIT_MAX = 2048
) (
   input  logic                               avl_clk,
   input  logic                               avl_rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]       req_len,
   output logic [NUM_REQ-1:0]                 req_ack,
   output logic                               gnt_valid,
   input  logic                               gnt_ready,
   output logic [$clog2(NUM_REQ)-1:0]         gnt_idx,
   output logic [TAG_WIDTH-1:0]               gnt_tag,
   output logic [LEN_WIDTH-1:0]               gnt_len,
   input  logic                               cpl_done_valid,
   input  logic [TAG_WIDTH-1:0]               cpl_done_tag,
   output logic [$clog2(NUM_TAGS):0]          tags_free,
   output logic [$clog2(CPL_CREDIT_MAX):0]    credit_avail,
   output logic                               err_tag_release
`ifdef PCIE_MRD_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]              grant_cnt,
   output logic [$clog2(NUM_TAGS):0]          max_outstanding
`endif
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int TIDX_W = $clog2(NUM_TAGS);
   localparam int CNT_W  = TIDX_W + 1;
   localparam int CR_W   = $clog2(CPL_CREDIT_MAX) + 1;
   localparam int EL_W   = LEN_WIDTH + 1;

   typedef enum logic [0:0] {ST_IDLE, ST_GRANT} state_t;

   state_t               state_q, state_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic [TAG_WIDTH-1:0] gnt_tag_q, gnt_tag_d;
   logic [LEN_WIDTH-1:0] gnt_len_q, gnt_len_d;
   logic [IDX_W-1:0]     rr_q, rr_d;
   logic [NUM_TAGS-1:0]  tag_busy_q, tag_busy_d;
   logic [CNT_W-1:0]     tags_free_q, tags_free_d;
   logic [CR_W-1:0]      credit_q, credit_d;
   logic                 err_q, err_d;

   // Effective length of every tag currently outstanding.
   logic [EL_W-1:0]      len_ram [NUM_TAGS];

   logic [EL_W-1:0]      req_l [NUM_REQ];
   logic [NUM_REQ-1:0]   elig;
   logic                 sel_found;
   logic [IDX_W-1:0]     sel_idx;
   logic [TIDX_W-1:0]    free_tag;

   logic                 accept;
   logic                 rel_ok;
   logic [TIDX_W-1:0]    rel_idx;
   logic [TIDX_W-1:0]    gnt_tag_idx;
   logic [EL_W-1:0]      gnt_l;
   logic [EL_W-1:0]      rel_l;

   // A length field of zero encodes the maximum transfer.
   function automatic logic [EL_W-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
      return (len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len};
   endfunction

   // Eligibility per requester and round-robin pick starting at the RR pointer.
   always_comb begin
      elig      = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_l[i] = eff_len(req_len[i*LEN_WIDTH +: LEN_WIDTH]);
         elig[IDX_W'(i)] = req_valid[IDX_W'(i)] && (tags_free_q != '0) &&
                           (32'(req_l[i]) <= 32'(credit_q));
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         int unsigned cand;
         cand = (32'(rr_q) + k) % NUM_REQ;
         if (!sel_found && elig[IDX_W'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(cand);
         end
      end
   end

   // Lowest-numbered free tag.
   always_comb begin
      logic found;
      found    = 1'b0;
      free_tag = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (!found && !tag_busy_q[TIDX_W'(i)]) begin
            found    = 1'b1;
            free_tag = TIDX_W'(i);
         end
      end
   end

   // FSM next state, grant registers and the combinational acknowledge pulse.
   always_comb begin
      state_d     = state_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_tag_d   = gnt_tag_q;
      gnt_len_d   = gnt_len_q;
      rr_d        = rr_q;
      req_ack     = '0;
      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               gnt_idx_d   = sel_idx;
               gnt_tag_d   = TAG_WIDTH'(free_tag);
               gnt_len_d   = req_len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
               gnt_valid_d = 1'b1;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (gnt_ready) begin
               req_ack[gnt_idx_q] = 1'b1;
               rr_d        = (32'(gnt_idx_q) == NUM_REQ - 1) ? '0 : gnt_idx_q + 1'b1;
               gnt_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Tag bitmap and credit bookkeeping. A release naming the tag being
   // accepted this cycle sees it still free, so it falls out as invalid.
   always_comb begin
      accept      = (state_q == ST_GRANT) && gnt_ready;
      gnt_tag_idx = TIDX_W'(gnt_tag_q);
      gnt_l       = eff_len(gnt_len_q);
      rel_idx     = TIDX_W'(cpl_done_tag);
      rel_ok      = cpl_done_valid && (32'(cpl_done_tag) < NUM_TAGS) && tag_busy_q[rel_idx];
      rel_l       = len_ram[rel_idx];

      tag_busy_d = tag_busy_q;
      if (rel_ok) tag_busy_d[rel_idx] = 1'b0;
      if (accept) tag_busy_d[gnt_tag_idx] = 1'b1;

      tags_free_d = tags_free_q - CNT_W'(accept) + CNT_W'(rel_ok);
      credit_d    = credit_q - (accept ? CR_W'(gnt_l) : '0) + (rel_ok ? CR_W'(rel_l) : '0);
      err_d       = err_q | (cpl_done_valid & ~rel_ok);
   end

   // State registers.
   always_ff @(posedge avl_clk or negedge avl_rst_n) begin
      if (!avl_rst_n) begin
         state_q     <= ST_IDLE;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         gnt_tag_q   <= '0;
         gnt_len_q   <= '0;
         rr_q        <= '0;
         tag_busy_q  <= '0;
         tags_free_q <= CNT_W'(NUM_TAGS);
         credit_q    <= CR_W'(CPL_CREDIT_MAX);
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_tag_q   <= gnt_tag_d;
         gnt_len_q   <= gnt_len_d;
         rr_q        <= rr_d;
         tag_busy_q  <= tag_busy_d;
         tags_free_q <= tags_free_d;
         credit_q    <= credit_d;
         err_q       <= err_d;
      end
   end

   // Length RAM written on grant acceptance; contents are only meaningful for busy tags.
   always_ff @(posedge avl_clk) begin
      if (accept) len_ram[gnt_tag_idx] <= gnt_l;
   end

   assign gnt_valid       = gnt_valid_q;
   assign gnt_idx         = gnt_idx_q;
   assign gnt_tag         = gnt_tag_q;
   assign gnt_len         = gnt_len_q;
   assign tags_free       = tags_free_q;
   assign credit_avail    = credit_q;
   assign err_tag_release = err_q;

`ifdef PCIE_MRD_SCHED_STATS_EN
   logic [NUM_REQ*32-1:0] grant_cnt_q, grant_cnt_d;
   logic [CNT_W-1:0]      max_out_q, max_out_d;
   logic [CNT_W-1:0]      busy_next;

   // Saturating per-requester grant counters and busy-tag high-water mark.
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_ack[IDX_W'(i)] && (grant_cnt_q[i*32 +: 32] != '1))
            grant_cnt_d[i*32 +: 32] = grant_cnt_q[i*32 +: 32] + 32'd1;
      end
      busy_next = CNT_W'(NUM_TAGS) - tags_free_d;
      max_out_d = (busy_next > max_out_q) ? busy_next : max_out_q;
   end

   // Statistics registers.
   always_ff @(posedge avl_clk or negedge avl_rst_n) begin
      if (!avl_rst_n) begin
         grant_cnt_q <= '0;
         max_out_q   <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         max_out_q   <= max_out_d;
      end
   end

   assign grant_cnt       = grant_cnt_q;
   assign max_outstanding = max_out_q;
`endif

endmodule

// File: tb/tb_pcie_mrd_tag_sched.sv
// Self-checking bench for pcie_mrd_tag_sched: directed scenarios followed by a
// randomized run, all checked cycle by cycle against a transaction-level model.
module tb_pcie_mrd_tag_sched;

   localparam int NR = 4;
   localparam int TW = 8;
   localparam int NT = 64;
   localparam int LW = 10;
   localparam int CM = 2048;

   logic              avl_clk = 1'b0;
   logic              avl_rst_n = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*LW-1:0]  req_len = '0;
   logic [NR-1:0]     req_ack;
   logic              gnt_valid;
   logic              gnt_ready = 1'b0;
   logic [1:0]        gnt_idx;
   logic [TW-1:0]     gnt_tag;
   logic [LW-1:0]     gnt_len;
   logic              cpl_done_valid = 1'b0;
   logic [TW-1:0]     cpl_done_tag = '0;
   logic [6:0]        tags_free;
   logic [11:0]       credit_avail;
   logic              err_tag_release;
`ifdef PCIE_MRD_SCHED_STATS_EN
   logic [NR*32-1:0]  grant_cnt;
   logic [6:0]        max_outstanding;
`endif

   always #5 avl_clk = ~avl_clk;

   pcie_mrd_tag_sched #(
      .NUM_REQ(NR), .TAG_WIDTH(TW), .NUM_TAGS(NT), .LEN_WIDTH(LW), .CPL_CREDIT_MAX(CM)
   ) dut (
      .avl_clk(avl_clk), .avl_rst_n(avl_rst_n),
      .req_valid(req_valid), .req_len(req_len), .req_ack(req_ack),
      .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_idx(gnt_idx),
      .gnt_tag(gnt_tag), .gnt_len(gnt_len),
      .cpl_done_valid(cpl_done_valid), .cpl_done_tag(cpl_done_tag),
      .tags_free(tags_free), .credit_avail(credit_avail),
      .err_tag_release(err_tag_release)
`ifdef PCIE_MRD_SCHED_STATS_EN
      , .grant_cnt(grant_cnt), .max_outstanding(max_outstanding)
`endif
   );

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // Reference model: outstanding-tag set with per-tag length, credit pool,
   // the pending grant, and per-requester queues of requested lengths.
   bit  m_busy [NT];
   int  m_lmem [NT];
   int  m_credit;
   bit  m_err;
   bit  m_gv;
   int  m_idx, m_tag, m_len;
   int  m_rr;
   int  m_hw;
   int  ack_cnt [NR];
   int  rq [NR][$];
   int  acc_idx [$];
   int  acc_tag [$];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   function automatic int eff(input int l);
      return (l == 0) ? 1024 : l;
   endfunction

   function automatic int free_cnt();
      int c = 0;
      for (int i = 0; i < NT; i++) if (!m_busy[i]) c++;
      return c;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      avl_rst_n = 1'b0;
      gnt_ready = 1'b0;
      cpl_done_valid = 1'b0;
      req_valid = '0;
      for (int i = 0; i < NR; i++) begin rq[i].delete(); ack_cnt[i] = 0; end
      for (int i = 0; i < NT; i++) begin m_busy[i] = 1'b0; m_lmem[i] = 0; end
      m_credit = CM; m_err = 0; m_gv = 0; m_idx = 0; m_tag = 0; m_len = 0; m_rr = 0; m_hw = 0;
      acc_idx.delete(); acc_tag.delete();
      #2;
      check("rst_gnt_valid", gnt_valid, 0);
      check("rst_gnt_idx", gnt_idx, 0);
      check("rst_gnt_tag", gnt_tag, 0);
      check("rst_gnt_len", gnt_len, 0);
      check("rst_req_ack", req_ack, 0);
      check("rst_tags_free", tags_free, NT);
      check("rst_credit", credit_avail, CM);
      check("rst_err", err_tag_release, 0);
      repeat (2) @(posedge avl_clk);
      #1;
      avl_rst_n = 1'b1;
   endtask

   // One clock: drive requests, compare outputs, then advance the model over the edge.
   task automatic cycle();
      logic [NR-1:0] exp_ack;
      bit found;
      int g_idx, g_tag, g_len;
      bit acc;
      int t;
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = (rq[i].size() > 0);
         req_len[i*LW +: LW] = (rq[i].size() > 0) ? LW'(rq[i][0]) : '0;
      end
      #2;
      acc = m_gv && gnt_ready;
      exp_ack = acc ? (NR'(1) << m_idx) : '0;
      check("gnt_valid", gnt_valid, m_gv);
      if (m_gv) begin
         check("gnt_idx", gnt_idx, m_idx);
         check("gnt_tag", gnt_tag, m_tag);
         check("gnt_len", gnt_len, m_len);
      end
      check("req_ack", req_ack, exp_ack);
      check("tags_free", tags_free, free_cnt());
      check("credit_avail", credit_avail, m_credit);
      check("err_tag_release", err_tag_release, m_err);
      if (acc) begin
         acc_idx.push_back(int'(gnt_idx));
         acc_tag.push_back(int'(gnt_tag));
      end
      found = 0; g_idx = 0; g_tag = 0; g_len = 0;
      if (!m_gv && free_cnt() > 0) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (!found && rq[i].size() > 0 && eff(rq[i][0]) <= m_credit) begin
               found = 1; g_idx = i; g_tag = lowest_free(); g_len = rq[i][0];
            end
         end
      end
      if (cpl_done_valid) begin
         t = int'(cpl_done_tag);
         if (t < NT && m_busy[t]) begin
            m_busy[t] = 0;
            m_credit += m_lmem[t];
         end else m_err = 1;
      end
      if (acc) begin
         m_busy[m_tag] = 1;
         m_lmem[m_tag] = eff(m_len);
         m_credit -= eff(m_len);
         m_rr = (m_idx + 1) % NR;
         m_gv = 0;
         void'(rq[m_idx].pop_front());
         ack_cnt[m_idx]++;
      end else if (found) begin
         m_gv = 1; m_idx = g_idx; m_tag = g_tag; m_len = g_len;
      end
      if (NT - free_cnt() > m_hw) m_hw = NT - free_cnt();
      @(posedge avl_clk);
      #1;
      cpl_done_valid = 1'b0;
   endtask

   task automatic release_tag(input int t);
      cpl_done_valid = 1'b1;
      cpl_done_tag = TW'(t);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, s, t;
      #1;
      // Single request of 16 DW.
      do_reset();
      rq[0].push_back(16);
      cycle();
      check("t1_gnt_valid", gnt_valid, 1);
      check("t1_gnt_idx", gnt_idx, 0);
      check("t1_gnt_tag", gnt_tag, 0);
      check("t1_gnt_len", gnt_len, 16);
      gnt_ready = 1'b1;
      cycle();
      gnt_ready = 1'b0;
      check("t1_tags_free", tags_free, 63);
      check("t1_credit", credit_avail, 2032);
      cycle();

      // Round robin across all four requesters.
      do_reset();
      for (int i = 0; i < NR; i++) rq[i].push_back(1);
      rq[0].push_back(1);
      gnt_ready = 1'b1;
      repeat (12) cycle();
      check("t2_count", acc_idx.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < acc_idx.size()) begin
            check("t2_order", acc_idx[i], i % NR);
            check("t2_tag", acc_tag[i], i);
         end
      end

      // Credit exhaustion with 1024 DW reads.
      do_reset();
      rq[0].push_back(0);
      rq[1].push_back(0);
      rq[2].push_back(1);
      gnt_ready = 1'b1;
      repeat (8) cycle();
      check("t3_credit_zero", credit_avail, 0);
      check("t3_stall", gnt_valid, 0);
      check("t3_tags_free", tags_free, 62);
      release_tag(0);
      cycle();
      repeat (3) cycle();
      check("t3_credit_after", credit_avail, 1023);
      check("t3_third_idx", acc_idx[acc_idx.size()-1], 2);

      // Tag exhaustion then release of tag 17.
      do_reset();
      repeat (NT) rq[0].push_back(1);
      gnt_ready = 1'b1;
      repeat (130) cycle();
      check("t4_tags_free", tags_free, 0);
      check("t4_credit", credit_avail, CM - NT);
      rq[1].push_back(1);
      repeat (4) cycle();
      check("t4_stall", gnt_valid, 0);
      release_tag(17);
      cycle();
      repeat (3) cycle();
      check("t4_regrant_tag", acc_tag[acc_tag.size()-1], 17);
      check("t4_regrant_idx", acc_idx[acc_idx.size()-1], 1);

      // Acceptance and release of another busy tag in the same cycle.
      gnt_ready = 1'b0;
      release_tag(5);
      rq[2].push_back(8);
      cycle();
      cycle();
      check("t5_gnt_tag", gnt_tag, 5);
      check("t5_free_before", tags_free, 1);
      gnt_ready = 1'b1;
      release_tag(9);
      cycle();
      gnt_ready = 1'b0;
      check("t5_free_net", tags_free, 1);
      check("t5_credit_net", credit_avail, 1978);
      release_tag(9);
      cycle();
      check("t5_err", err_tag_release, 1);
      check("t5_free_kept", tags_free, 1);
      check("t5_credit_kept", credit_avail, 1978);
      release_tag(200);
      cycle();
      check("t5_credit_oor", credit_avail, 1978);

      // Grant held under backpressure, then reset mid-hold.
      do_reset();
      rq[0].push_back(5);
      gnt_ready = 1'b1;
      repeat (3) cycle();
      gnt_ready = 1'b0;
      rq[3].push_back(33);
      cycle();
      repeat (10) cycle();
      check("t6_idx", gnt_idx, 3);
      check("t6_tag", gnt_tag, 1);
      check("t6_len", gnt_len, 33);
      check("t6_no_ack", req_ack, 0);
      do_reset();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NR; i++)
            if (rq[i].size() == 0 && $urandom_range(0, 3) == 0)
               rq[i].push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(1, 64));
         gnt_ready = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         if (r < 4) begin
            s = $urandom_range(0, NT-1);
            for (int k = 0; k < NT; k++) begin
               t = (s + k) % NT;
               if (m_busy[t]) begin release_tag(t); break; end
            end
         end else if (r == 4 && $urandom_range(0, 7) == 0) begin
            release_tag($urandom_range(0, 255));
         end else if (r == 5 && m_gv && $urandom_range(0, 3) == 0) begin
            release_tag(m_tag);
         end
         cycle();
      end
`ifdef PCIE_MRD_SCHED_STATS_EN
      for (int i = 0; i < NR; i++) check("stats_grant_cnt", grant_cnt[i*32 +: 32], ack_cnt[i]);
      check("stats_max_out", max_outstanding, m_hw);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
